// File: rtl/response_checker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : response_checker_pkg
//  Description : Shared constants for the truth-table response checker:
//                FSM state encoding, error-count ceiling and the default
//                truth table of the 3-input reference circuit.
//  Revision    : 1.0  initial release
// ============================================================================
package response_checker_pkg;

   // FSM state encoding (explicit 2-bit width)
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CHECK = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   // Ceiling of the mismatch counter
   localparam logic [7:0] ERR_MAX = 8'd255;

   // Truth table of the 3-input circuit: bit i is the output for input i
   localparam logic [7:0] DEFAULT_EXPECTED = 8'b1001_0110;

endpackage : response_checker_pkg
`default_nettype wire

// File: rtl/response_checker_sat_counter8.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter8
//  Description : 8-bit incrementer that sticks at its maximum value, with a
//                synchronous clear that has priority over increment.
//  Revision    : 1.0  initial release
// ============================================================================
module sat_counter8
   import response_checker_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       inc,
   output logic [7:0] count
);

   // Count up on inc, hold once the ceiling is reached, clear on reset/clear
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= 8'd0;
      end else if (inc && (count != ERR_MAX)) begin
         count <= count + 8'd1;
      end
   end

endmodule : sat_counter8
`default_nettype wire

// File: rtl/response_checker.sv
`default_nettype none
// ============================================================================
//  Module      : response_checker
//  Description : Observes each applied input vector and the DUT output,
//                checks it against a truth table, counts mismatches, tracks
//                vector coverage and ascending order, and gives a verdict.
//  Revision    : 1.0  initial release
// ============================================================================
module response_checker
   import response_checker_pkg::*;
#(
   parameter int                   N_IN     = 3,
   parameter logic [2**N_IN-1:0]   EXPECTED = DEFAULT_EXPECTED,
   parameter int                   SWEEPS   = 2
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 vec_valid,
   input  logic [N_IN-1:0]      vec_in,
   input  logic                 dut_out,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [7:0]           err_count,
   output logic                 seq_err,
   output logic [N_IN-1:0]      first_err_vec,
   output logic                 first_err_hit,
   output logic [2**N_IN-1:0]   coverage
);

   localparam int NV    = 2**N_IN;
   localparam int TOTAL = SWEEPS * NV;
   localparam int CNT_W = $clog2(TOTAL + 1);
   localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);

   logic [1:0]       r_state;
   logic [1:0]       w_next_state;
   logic [CNT_W-1:0] r_count;
   logic [N_IN-1:0]  r_exp_next;
   logic             w_enter;
   logic             w_sample;
   logic             w_mismatch;

   // A run (re)starts from IDLE or DONE; starts during CHECK are ignored.
   assign w_enter    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
   // Samples are taken only in CHECK and only until the run's quota is met,
   // so the final count is frozen during the cycle that moves to DONE.
   assign w_sample   = (r_state == ST_CHECK) && vec_valid && (r_count != TOTAL_C);
   assign w_mismatch = dut_out ^ EXPECTED[vec_in];

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic: DONE follows the cycle in which the quota was reached
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:  if (start) w_next_state = ST_CHECK;
         ST_CHECK: if (r_count == TOTAL_C) w_next_state = ST_DONE;
         ST_DONE:  if (start) w_next_state = ST_CHECK;
         default:  w_next_state = ST_IDLE;
      endcase
   end

   // Status outputs decoded from the state and the registered results
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      pass = 1'b0;
      case (r_state)
         ST_CHECK: busy = 1'b1;
         ST_DONE: begin
            done = 1'b1;
            pass = (err_count == 8'd0) && (&coverage) && !seq_err;
         end
         default: ;
      endcase
   end

   // Sample bookkeeping: count, coverage, ordering and first-error capture
   always_ff @(posedge clk) begin
      if (reset || w_enter) begin
         r_count       <= '0;
         r_exp_next    <= '0;
         coverage      <= '0;
         seq_err       <= 1'b0;
         first_err_vec <= '0;
         first_err_hit <= 1'b0;
      end else if (w_sample) begin
         r_count          <= r_count + CNT_W'(1);
         coverage[vec_in] <= 1'b1;
         if (vec_in != r_exp_next) begin
            seq_err <= 1'b1;
         end
         // In order or not, the next expected vector follows the one seen,
         // so a single skip is flagged only once.
         r_exp_next <= vec_in + N_IN'(1);
         if (w_mismatch && !first_err_hit) begin
            first_err_vec <= vec_in;
            first_err_hit <= 1'b1;
         end
      end
   end

   // Saturating mismatch counter
   sat_counter8 u_err_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (w_enter),
      .inc   (w_sample && w_mismatch),
      .count (err_count)
   );

endmodule : response_checker
`default_nettype wire
